// File: rtl/vga_test_pattern_pkg.sv
// Shared definitions for the test-pattern source: pattern encodings, the checker
// square exponent and the colour-bar masks.
package vga_test_pattern_pkg;

  typedef enum logic [2:0] {
    PAT_BLACK   = 3'd0,
    PAT_RED     = 3'd1,
    PAT_GREEN   = 3'd2,
    PAT_BLUE    = 3'd3,
    PAT_CHECKER = 3'd4,
    PAT_BARS    = 3'd5,
    PAT_BORDER  = 3'd6,
    PAT_RSVD    = 3'd7
  } pattern_t;

  localparam int CNT_W     = 10;
  localparam int CHECK_EXP = 5;

  // Bit b of each mask says whether that channel is full-scale in bar b.
  localparam logic [7:0] BAR_RED_MASK = 8'b0011_0011;
  localparam logic [7:0] BAR_GRN_MASK = 8'b0000_1111;
  localparam logic [7:0] BAR_BLU_MASK = 8'b0101_0101;

endpackage

// File: rtl/vga_sync_counter.sv
// Recovers column/row position from the raw active-high sync pair; re-aligned on
// every start of frame and free-running in between.
module vga_sync_counter
  import vga_test_pattern_pkg::*;
#(
  parameter int TOTAL_COLS = 800,
  parameter int TOTAL_ROWS = 525
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ihsync,
  input  logic             ivsync,
  output logic             sof,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             hsync,
  output logic             vsync
);

  logic [CNT_W-1:0] col_reg, col_next;
  logic [CNT_W-1:0] row_reg, row_next;
  logic             hsync_reg, vsync_reg;
  logic             col_wrap;

  // The stage-1 vsync register doubles as the previous sample for edge detect.
  assign sof      = ivsync & ~vsync_reg;
  assign col_wrap = (col_reg == CNT_W'(TOTAL_COLS - 1));

  always_comb begin
    col_next = col_reg + 1'b1;
    row_next = row_reg;
    if (sof) begin
      col_next = '0;
      row_next = '0;
    end else if (col_wrap) begin
      col_next = '0;
      row_next = (row_reg == CNT_W'(TOTAL_ROWS - 1)) ? '0 : row_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_reg   <= '0;
      row_reg   <= '0;
      hsync_reg <= 1'b0;
      vsync_reg <= 1'b0;
    end else begin
      col_reg   <= col_next;
      row_reg   <= row_next;
      hsync_reg <= ihsync;
      vsync_reg <= ivsync;
    end
  end

  assign col   = col_reg;
  assign row   = row_reg;
  assign hsync = hsync_reg;
  assign vsync = vsync_reg;

endmodule

// File: rtl/vga_test_pattern.sv
// Selectable test-pattern source with 2-cycle sync/video alignment.
// Define VGA_TEST_PATTERN_ANIM_EN to scroll the checkerboard one pixel per frame.
module vga_test_pattern
  import vga_test_pattern_pkg::*;
#(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ihsync,
  input  logic                   ivsync,
  input  logic [2:0]             pattern,
  output logic                   ohsync,
  output logic                   ovsync,
  output logic [VIDEO_WIDTH-1:0] oredv,
  output logic [VIDEO_WIDTH-1:0] ogrnv,
  output logic [VIDEO_WIDTH-1:0] obluv
);

  localparam int BAR_W = ACTIVE_COLS / 8;
  localparam logic [VIDEO_WIDTH-1:0] FULL = '1;

  logic             sof;
  logic [CNT_W-1:0] col, row;
  logic             hsync1, vsync1;
  pattern_t         pattern_reg;
  logic             checker_on;
  logic             active;
  logic             on_border;
  logic [7:0]       bar_ge;
  logic [2:0]       bar_idx;
  logic [VIDEO_WIDTH-1:0] red_next, grn_next, blu_next;

  vga_sync_counter #(
    .TOTAL_COLS(TOTAL_COLS),
    .TOTAL_ROWS(TOTAL_ROWS)
  ) u_sync_counter (
    .clock (clock),
    .reset (reset),
    .ihsync(ihsync),
    .ivsync(ivsync),
    .sof   (sof),
    .col   (col),
    .row   (row),
    .hsync (hsync1),
    .vsync (vsync1)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_reg <= PAT_BLACK;
    end else if (sof) begin
      pattern_reg <= pattern_t'(pattern);
    end
  end

`ifdef VGA_TEST_PATTERN_ANIM_EN
  logic [CNT_W-1:0] offset_reg;
  logic             started_reg;

  // The first frame after reset is drawn unscrolled; each later SOF steps the offset.
  always_ff @(posedge clock) begin
    if (reset) begin
      offset_reg  <= '0;
      started_reg <= 1'b0;
    end else if (sof) begin
      started_reg <= 1'b1;
      if (started_reg) offset_reg <= offset_reg + 1'b1;
    end
  end

  assign checker_on = 1'((col + offset_reg) >> CHECK_EXP) ^ row[CHECK_EXP];
`else
  assign checker_on = col[CHECK_EXP] ^ row[CHECK_EXP];
`endif

  // Bar thresholds as a compare chain; the highest threshold passed is the bar index.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bar_ge
    assign bar_ge[gi] = (col >= CNT_W'(BAR_W * gi));
  end

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (bar_ge[i]) bar_idx = 3'(i);
    end
  end

  assign active    = (col < CNT_W'(ACTIVE_COLS)) && (row < CNT_W'(ACTIVE_ROWS));
  assign on_border = (col == '0) || (col == CNT_W'(ACTIVE_COLS - 1)) ||
                     (row == '0) || (row == CNT_W'(ACTIVE_ROWS - 1));

  always_comb begin
    red_next = '0;
    grn_next = '0;
    blu_next = '0;
    if (active) begin
      case (pattern_reg)
        PAT_RED:   red_next = FULL;
        PAT_GREEN: grn_next = FULL;
        PAT_BLUE:  blu_next = FULL;
        PAT_CHECKER: begin
          if (checker_on) begin
            red_next = FULL;
            grn_next = FULL;
            blu_next = FULL;
          end
        end
        PAT_BARS: begin
          red_next = {VIDEO_WIDTH{BAR_RED_MASK[bar_idx]}};
          grn_next = {VIDEO_WIDTH{BAR_GRN_MASK[bar_idx]}};
          blu_next = {VIDEO_WIDTH{BAR_BLU_MASK[bar_idx]}};
        end
        PAT_BORDER: begin
          if (on_border) begin
            red_next = FULL;
            grn_next = FULL;
            blu_next = FULL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ohsync <= 1'b0;
      ovsync <= 1'b0;
      oredv  <= '0;
      ogrnv  <= '0;
      obluv  <= '0;
    end else begin
      ohsync <= hsync1;
      ovsync <= vsync1;
      oredv  <= red_next;
      ogrnv  <= grn_next;
      obluv  <= blu_next;
    end
  end

endmodule

// File: tb/tb_vga_test_pattern.sv
// Scoreboard bench for vga_test_pattern on a reduced raster (100x50, 80x40 active).
module tb_vga_test_pattern;

  localparam int VW = 3;
  localparam int TC = 100;
  localparam int TR = 50;
  localparam int AC = 80;
  localparam int AR = 40;
  localparam int FRAME = TC * TR;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ihsync = 1'b0;
  logic          ivsync = 1'b0;
  logic [2:0]    pattern = 3'd0;
  logic          ohsync, ovsync;
  logic [VW-1:0] oredv, ogrnv, obluv;

  vga_test_pattern #(
    .VIDEO_WIDTH(VW),
    .TOTAL_COLS (TC),
    .TOTAL_ROWS (TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .ihsync (ihsync),
    .ivsync (ivsync),
    .pattern(pattern),
    .ohsync (ohsync),
    .ovsync (ovsync),
    .oredv  (oredv),
    .ogrnv  (ogrnv),
    .obluv  (obluv)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3*VW+1:0] v;
    int              c;
    int              r;
    int              p;
  } sb_t;

  sb_t        sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         col_r = 0;
  int         row_r = 45;
  logic       prev_vs_m = 1'b0;
  logic [2:0] pat_m = 3'd0;
  logic [9:0] off_m = 10'd0;
  logic       seen_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3*VW-1:0] exp_rgb(input int c, input int r,
                                               input logic [2:0] p, input logic [9:0] off);
    logic [VW-1:0] f;
    logic [VW-1:0] z;
    int x, b;
    f = '1;
    z = '0;
    if (c >= AC || r >= AR) return '0;
    case (p)
      3'd1: return {f, z, z};
      3'd2: return {z, f, z};
      3'd3: return {z, z, f};
      3'd4: begin
        x = (c + int'(off)) % 1024;
        return (((x / 32) % 2) != ((r / 32) % 2)) ? {f, f, f} : '0;
      end
      3'd5: begin
        b = c / (AC / 8);
        return {(b == 0 || b == 1 || b == 4 || b == 5) ? f : z,
                (b <= 3) ? f : z,
                (b % 2 == 0) ? f : z};
      end
      3'd6: return (c == 0 || c == AC - 1 || r == 0 || r == AR - 1) ? {f, f, f} : '0;
      default: return '0;
    endcase
  endfunction

  task automatic advance_raster();
    col_r++;
    if (col_r == TC) begin
      col_r = 0;
      row_r = (row_r == TR - 1) ? 0 : row_r + 1;
    end
  endtask

  task automatic drive_part(input bit push);
    sb_t e;
    ihsync = (col_r < AC);
    ivsync = (row_r < AR);
    if (push) begin
      if (ivsync && !prev_vs_m) begin
`ifdef VGA_TEST_PATTERN_ANIM_EN
        if (seen_m) off_m = off_m + 10'd1;
        seen_m = 1'b1;
`endif
        pat_m = pattern;
      end
      prev_vs_m = ivsync;
      e.v = {ihsync, ivsync, exp_rgb(col_r, row_r, pat_m, off_m)};
      e.c = col_r;
      e.r = row_r;
      e.p = int'(pat_m);
      sb_q.push_back(e);
    end
    advance_raster();
  endtask

  task automatic step();
    sb_t e;
    @(negedge clock);
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      check_eq($sformatf("pix p%0d c%0d r%0d", e.p, e.c, e.r),
               32'({ohsync, ovsync, oredv, ogrnv, obluv}), 32'(e.v));
    end
    drive_part(1'b1);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    sb_t z;
    @(negedge clock);
    reset = 1'b1;
    drive_part(1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_eq("rst outputs", 32'({ohsync, ovsync, oredv, ogrnv, obluv}), 32'd0);
      drive_part(1'b0);
    end
    @(negedge clock);
    reset = 1'b0;
    sb_q.delete();
    // The stage-2 registers still show stage-1 reset contents one cycle after release.
    z.v = '0;
    z.c = -1;
    z.r = -1;
    z.p = 0;
    sb_q.push_back(z);
    prev_vs_m = 1'b0;
    pat_m = 3'd0;
    off_m = 10'd0;
    seen_m = 1'b0;
    drive_part(1'b1);
  endtask

  initial begin
    pattern = 3'd1;
    do_reset(5);
    run_cycles(FRAME);
    pattern = 3'd5;
    run_cycles(FRAME);
    pattern = 3'd4;
    run_cycles(2 * FRAME);
    pattern = 3'd6;
    run_cycles(FRAME);
    pattern = 3'd1;
    run_cycles((TR - 45 + 20) * TC);
    pattern = 3'd2;
    run_cycles(FRAME + 25 * TC);
    pattern = 3'd3;
    run_cycles(FRAME);
    pattern = 3'd7;
    run_cycles(FRAME);
    pattern = 3'd5;
    do_reset(5);
    run_cycles(FRAME);
    pattern = 3'd0;
    run_cycles(FRAME / 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
